// File: rtl/serial_comparator.sv
// Bit-serial unsigned magnitude comparator: loads two operands on start and
// examines one bit pair per clock, MSB first, reporting g/e/l with a done pulse.
module serial_comparator #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic                       busy,
    output logic                       done,
    output logic                       g,
    output logic                       e,
    output logic                       l,
    output logic [$clog2(WIDTH+1)-1:0] cycles
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [IW-1:0]    idx;
    logic             found;
    logic             found_gt;

    logic bit_gt;
    logic bit_lt;
    logic any_mismatch;
    logic result_gt;
    logic finish;

    // The current bit pair always sits at the MSB of the shift registers.
    assign bit_gt       = sh_a[WIDTH-1] & ~sh_b[WIDTH-1];
    assign bit_lt       = ~sh_a[WIDTH-1] & sh_b[WIDTH-1];
    assign any_mismatch = found | bit_gt | bit_lt;
    assign result_gt    = found ? found_gt : bit_gt;
    assign finish       = (EARLY_EXIT && (bit_gt || bit_lt)) || (idx == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = (state == DONE);
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (finish) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath; the sticky flag keeps the first mismatch when scanning every bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a     <= '0;
            sh_b     <= '0;
            idx      <= '0;
            found    <= 1'b0;
            found_gt <= 1'b0;
            g        <= 1'b0;
            e        <= 1'b0;
            l        <= 1'b0;
            cycles   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a     <= a;
                        sh_b     <= b;
                        idx      <= IW'(WIDTH - 1);
                        found    <= 1'b0;
                        found_gt <= 1'b0;
                        g        <= 1'b0;
                        e        <= 1'b0;
                        l        <= 1'b0;
                        cycles   <= '0;
                    end
                end
                RUN: begin
                    sh_a <= sh_a << 1;
                    sh_b <= sh_b << 1;
                    if (cycles != CW'(WIDTH)) begin
                        cycles <= cycles + CW'(1);
                    end
                    if (idx != '0) begin
                        idx <= idx - IW'(1);
                    end
                    if (!found && (bit_gt || bit_lt)) begin
                        found    <= 1'b1;
                        found_gt <= bit_gt;
                    end
                    if (finish) begin
                        g <= any_mismatch & result_gt;
                        l <= any_mismatch & ~result_gt;
                        e <= ~any_mismatch;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_comparator.sv
// Self-checking bench: three comparator instances (early exit, full scan, 1-bit)
// driven with directed and random operands against an arithmetic reference.
module tb_serial_comparator;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a     = '0;
    logic [7:0] b     = '0;
    logic       a1    = 1'b0;
    logic       b1    = 1'b0;

    logic       busy_x, done_x, g_x, e_x, l_x;
    logic [3:0] cycles_x;
    logic       busy_f, done_f, g_f, e_f, l_f;
    logic [3:0] cycles_f;
    logic       busy_s, done_s, g_s, e_s, l_s;
    logic [0:0] cycles_s;

    int n_checks = 0;
    int n_errors = 0;

    serial_comparator #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_early (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy_x), .done(done_x), .g(g_x), .e(e_x), .l(l_x), .cycles(cycles_x)
    );

    serial_comparator #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_full (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy_f), .done(done_f), .g(g_f), .e(e_f), .l(l_f), .cycles(cycles_f)
    );

    serial_comparator #(.WIDTH(1), .EARLY_EXIT(1'b1)) u_single (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a1), .b(b1),
        .busy(busy_s), .done(done_s), .g(g_s), .e(e_s), .l(l_s), .cycles(cycles_s)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Bit pairs examined with early exit: WIDTH minus the position of the top differing bit.
    function automatic int early_cycles(input logic [7:0] x, input logic [7:0] y);
        int d;
        int top;
        d   = int'(x ^ y);
        top = -1;
        while (d > 0) begin
            top++;
            d = d >> 1;
        end
        return (top < 0) ? 8 : 8 - top;
    endfunction

    task automatic check_all_zero(input string tag);
        check_output({tag, "_early"}, {busy_x, done_x, g_x, e_x, l_x, cycles_x}, 0);
        check_output({tag, "_full"}, {busy_f, done_f, g_f, e_f, l_f, cycles_f}, 0);
        check_output({tag, "_single"}, {busy_s, done_s, g_s, e_s, l_s, cycles_s}, 0);
    endtask

    // One compare: accept, optionally pulse a second start while busy, observe 14 cycles.
    task automatic apply_stimulus(input logic [7:0] av, input logic [7:0] bv,
                                  input logic a1v, input logic b1v,
                                  input bit interfere, input string tag);
        int lat_x, lat_f, lat_s;
        int pulses_x, pulses_f, pulses_s;
        int exp_cyc;
        lat_x = 0; lat_f = 0; lat_s = 0;
        pulses_x = 0; pulses_f = 0; pulses_s = 0;

        @(negedge clk);
        a = av; b = bv; a1 = a1v; b1 = b1v; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a  = 8'($urandom);
        b  = 8'($urandom);
        a1 = 1'($urandom);
        b1 = 1'($urandom);
        check_output({tag, "_busy_run"}, busy_f, 1);
        check_output({tag, "_gel_run"}, {g_f, e_f, l_f}, 0);

        for (int t = 1; t <= 14; t++) begin
            @(negedge clk);
            if (done_x) begin pulses_x++; if (lat_x == 0) lat_x = t; end
            if (done_f) begin pulses_f++; if (lat_f == 0) lat_f = t; end
            if (done_s) begin pulses_s++; if (lat_s == 0) lat_s = t; end
            if (interfere && t == 1) begin
                a = bv; b = av; a1 = b1v; b1 = a1v; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end

        exp_cyc = early_cycles(av, bv);
        check_output({tag, "_early_lat"}, lat_x, exp_cyc);
        check_output({tag, "_early_pulses"}, pulses_x, 1);
        check_output({tag, "_early_gel"}, {g_x, e_x, l_x}, {av > bv, av == bv, av < bv});
        check_output({tag, "_early_cycles"}, cycles_x, exp_cyc);

        check_output({tag, "_full_lat"}, lat_f, 8);
        check_output({tag, "_full_pulses"}, pulses_f, 1);
        check_output({tag, "_full_gel"}, {g_f, e_f, l_f}, {av > bv, av == bv, av < bv});
        check_output({tag, "_full_cycles"}, cycles_f, 8);

        check_output({tag, "_single_lat"}, lat_s, 1);
        check_output({tag, "_single_pulses"}, pulses_s, 1);
        check_output({tag, "_single_gel"}, {g_s, e_s, l_s}, {a1v > b1v, a1v == b1v, a1v < b1v});
        check_output({tag, "_single_cycles"}, cycles_s, 1);
        check_output({tag, "_idle"}, {busy_x, busy_f, busy_s}, 0);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        int         done_seen;

        $display("[TB] serial_comparator bench start");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset_idle");

        apply_stimulus(8'hA5, 8'hA5, 1'b1, 1'b1, 1'b0, "equal_a5");
        apply_stimulus(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, "msb_gt");
        apply_stimulus(8'h12, 8'h13, 1'b0, 1'b1, 1'b0, "lsb_lt");

        // Result must hold in IDLE with new operands present and no start.
        a = 8'hFF; b = 8'h00;
        repeat (4) @(negedge clk);
        check_output("hold_early", {g_x, e_x, l_x, cycles_x}, {3'b001, 4'd8});
        check_output("hold_full", {g_f, e_f, l_f, cycles_f}, {3'b001, 4'd8});

        apply_stimulus(8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, "ignore_start");
        apply_stimulus(8'h01, 8'h00, 1'b0, 1'b0, 1'b0, "bit0_gt");

        // Reset in the middle of a compare.
        @(negedge clk);
        a = 8'h3C; b = 8'h3C; a1 = 1'b1; b1 = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset_mid_run");
        done_seen = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (t == 2) rst_n = 1'b1;
            if (done_x || done_f || done_s) done_seen++;
        end
        check_output("no_done_after_reset", done_seen, 0);
        check_all_zero("post_reset_idle");
        apply_stimulus(8'hC3, 8'hC1, 1'b1, 1'b0, 1'b0, "fresh_after_reset");

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            case ($urandom_range(0, 2))
                0:       rb = ra;
                1:       rb = ra ^ (8'd1 << $urandom_range(0, 7));
                default: rb = 8'($urandom);
            endcase
            apply_stimulus(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom), $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
